tsu_ts_reader: RTL and testbench

Host-side readout stage for the TSU timestamp queue. Sits downstream of `tsu` in the `q_rd_clk` domain. Pops one 128-bit entry at a time from the queue into a holding register and exposes it to the CPU as four 32-bit words over a simple register bus. Provides occupancy status, a consumed-entry counter and a level interrupt.

---
 rtl/tsu_pkg.sv | 46 ++++
 rtl/tsu_ts_reader_if.sv | 14 +
 rtl/tsu_ts_reader.sv | 125 ++++++++++++
 tb/tb_tsu_ts_reader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tsu_pkg.sv
// Shared definitions for the TSU timestamp readout path: register map, CTRL bits,
// queue entry field layout and reader FSM encoding.
package tsu_pkg;

    localparam int BUS_AW   = 3;
    localparam int BUS_DW   = 32;
    localparam int ENTRY_W  = 128;
    localparam int LVL_W    = 4;
    localparam int CNT_W    = 16;

    localparam logic [BUS_AW-1:0] ADDR_STAT  = 3'd0;
    localparam logic [BUS_AW-1:0] ADDR_CTRL  = 3'd1;
    localparam logic [BUS_AW-1:0] ADDR_DATA0 = 3'd2;
    localparam logic [BUS_AW-1:0] ADDR_DATA1 = 3'd3;
    localparam logic [BUS_AW-1:0] ADDR_DATA2 = 3'd4;
    localparam logic [BUS_AW-1:0] ADDR_DATA3 = 3'd5;

    localparam int CTRL_RELEASE_BIT = 0;
    localparam int CTRL_CLEAR_BIT   = 1;
    localparam int CTRL_AUTOPOP_BIT = 2;

    // Entry layout: {16'd0, sec48, ns32, msgId4, ckSum12, seqId16}
    localparam int SEQID_LSB = 0;
    localparam int SEQID_W   = 16;
    localparam int CKSUM_LSB = 16;
    localparam int CKSUM_W   = 12;
    localparam int MSGID_LSB = 28;
    localparam int MSGID_W   = 4;
    localparam int NS_LSB    = 32;
    localparam int NS_W      = 32;
    localparam int SEC_LSB   = 64;
    localparam int SEC_W     = 48;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } rd_state_e;

    function automatic logic [BUS_DW-1:0] entry_word(input logic [ENTRY_W-1:0] e,
                                                     input logic [1:0] idx);
        return e[idx*BUS_DW +: BUS_DW];
    endfunction

endpackage

// File: rtl/tsu_ts_reader_if.sv
// CPU-side register bus of the timestamp reader: single-cycle strobes, registered read data.
interface tsu_ts_reader_if;
    import tsu_pkg::*;

    logic [BUS_AW-1:0] bus_addr;
    logic              bus_rd;
    logic              bus_wr;
    logic [BUS_DW-1:0] bus_wdata;
    logic [BUS_DW-1:0] bus_rdata;

    modport master (output bus_addr, bus_rd, bus_wr, bus_wdata, input bus_rdata);
    modport slave  (input bus_addr, bus_rd, bus_wr, bus_wdata, output bus_rdata);

endinterface

// File: rtl/tsu_ts_reader.sv
// Pops one timestamp entry at a time from the TSU queue into a holding register
// and exposes it as four 32-bit words plus status, consumed count and a level irq.
module tsu_ts_reader
    import tsu_pkg::*;
#(
    parameter int RD_LATENCY   = 1,
    parameter bit AUTO_POP_RST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 q_rd_en,
    input  logic [7:0]           q_rd_stat,
    input  logic [ENTRY_W-1:0]   q_rd_data,
    tsu_ts_reader_if.slave       bus,
    output logic                 irq
);

    localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

    rd_state_e            state_q, state_d;
    logic [1:0]           lat_cnt_q, lat_cnt_d;
    logic [ENTRY_W-1:0]   hold_q, hold_d;
    logic                 hold_valid_q, hold_valid_d;
    logic [CNT_W-1:0]     cons_cnt_q, cons_cnt_d;
    logic                 auto_pop_q, auto_pop_d;
    logic [BUS_DW-1:0]    rdata_q, rdata_d;

    logic                 ctrl_wr;
    logic                 release_ev;
    logic                 unused_bits;

    assign unused_bits   = ^{q_rd_stat[7:4], bus.bus_wdata[BUS_DW-1:3]};
    assign irq           = hold_valid_q;
    assign bus.bus_rdata = rdata_q;

    function automatic logic [BUS_DW-1:0] read_word(input logic [BUS_AW-1:0] addr);
        logic [BUS_AW-1:0] off;
        off = addr - ADDR_DATA0;
        case (addr)
            ADDR_STAT:  return {cons_cnt_q, 7'd0, hold_valid_q, 4'd0, q_rd_stat[LVL_W-1:0]};
            ADDR_CTRL:  return {29'd0, auto_pop_q, 2'b00};
            ADDR_DATA0, ADDR_DATA1, ADDR_DATA2, ADDR_DATA3:
                return hold_valid_q ? entry_word(hold_q, off[1:0]) : '0;
            default:    return '0;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        cons_cnt_d   = cons_cnt_q;
        auto_pop_d   = auto_pop_q;
        rdata_d      = rdata_q;
        q_rd_en      = 1'b0;

        ctrl_wr    = bus.bus_wr && (bus.bus_addr == ADDR_CTRL);
        // A CTRL release and an auto-pop DATA3 read collapse into a single event.
        release_ev = hold_valid_q && (state_q == ST_HOLD) &&
                     ((ctrl_wr && bus.bus_wdata[CTRL_RELEASE_BIT]) ||
                      (bus.bus_rd && (bus.bus_addr == ADDR_DATA3) && auto_pop_q));

        case (state_q)
            ST_IDLE: begin
                if (!hold_valid_q && (q_rd_stat[LVL_W-1:0] != '0))
                    state_d = ST_REQ;
            end
            ST_REQ: begin
                q_rd_en   = 1'b1;
                lat_cnt_d = '0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    hold_d       = q_rd_data;
                    hold_valid_d = 1'b1;
                    state_d      = ST_HOLD;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
            ST_HOLD: begin
                if (release_ev) begin
                    hold_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (ctrl_wr && bus.bus_wdata[CTRL_CLEAR_BIT])
            cons_cnt_d = '0;
        else if (release_ev)
            cons_cnt_d = cons_cnt_q + 16'd1;

        if (ctrl_wr)
            auto_pop_d = bus.bus_wdata[CTRL_AUTOPOP_BIT];

        // Reads sample pre-edge state, so an auto-pop DATA3 read returns the released entry.
        if (bus.bus_rd)
            rdata_d = read_word(bus.bus_addr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            lat_cnt_q    <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            cons_cnt_q   <= '0;
            auto_pop_q   <= AUTO_POP_RST;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            cons_cnt_q   <= cons_cnt_d;
            auto_pop_q   <= auto_pop_d;
            rdata_q      <= rdata_d;
        end
    end

endmodule

// File: tb/tb_tsu_ts_reader.sv
// Bench for tsu_ts_reader: queue responder, behavioural model with per-cycle compare,
// directed scenarios with literal expectations, then randomized bus/queue traffic.
module tb_tsu_ts_reader;
    import tsu_pkg::*;

    localparam int LAT = 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         q_rd_en;
    logic [7:0]   q_rd_stat;
    logic [127:0] q_rd_data;
    logic         irq;

    tsu_ts_reader_if bus_if();

    tsu_ts_reader #(.RD_LATENCY(LAT), .AUTO_POP_RST(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .q_rd_en   (q_rd_en),
        .q_rd_stat (q_rd_stat),
        .q_rd_data (q_rd_data),
        .bus       (bus_if),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [127:0] sq[$];
    logic [127:0] exp_q[$];

    bit           m_valid;
    logic [127:0] m_hold;
    logic [127:0] m_pend;
    logic [15:0]  m_cnt;
    bit           m_auto;
    logic [31:0]  m_rdata;
    int           m_fetch;
    bit           exp_rd_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic push(input logic [127:0] e);
        sq.push_back(e);
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a, input logic [3:0] lvl);
        case (a)
            3'd0:    return {m_cnt, 7'd0, m_valid, 4'd0, lvl};
            3'd1:    return {29'd0, m_auto, 2'b00};
            3'd2, 3'd3, 3'd4, 3'd5: return m_valid ? m_hold[32*(int'(a)-2) +: 32] : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Queue responder: pops on each read strobe, data ready before the capture edge.
    initial begin
        q_rd_data = '0;
        q_rd_stat = '0;
        forever begin
            @(negedge clk);
            if (q_rd_en === 1'b1 && sq.size() > 0) q_rd_data = sq.pop_front();
            q_rd_stat = {4'd0, 4'(sq.size())};
        end
    end

    // Behavioural model: an entry arrives 1+LAT edges after a fetch starts from an empty holder.
    initial begin
        bit       rel, ctrlw, pre_valid;
        logic [2:0]  a;
        logic [31:0] wd;
        logic [3:0]  lvl;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_valid = 0; m_hold = '0; m_cnt = '0; m_auto = 1; m_rdata = '0;
                m_fetch = -1; exp_rd_en = 0;
            end else begin
                a = bus_if.bus_addr; wd = bus_if.bus_wdata; lvl = q_rd_stat[3:0];
                pre_valid = m_valid;
                ctrlw = bus_if.bus_wr && (a == 3'd1);
                rel = pre_valid && ((ctrlw && wd[0]) || (bus_if.bus_rd && a == 3'd5 && m_auto));
                if (bus_if.bus_rd) m_rdata = model_read(a, lvl);
                if (ctrlw && wd[1]) m_cnt = 16'd0;
                else if (rel)       m_cnt = m_cnt + 16'd1;
                if (ctrlw) m_auto = wd[2];
                if (m_fetch > 0) begin
                    m_fetch--;
                    if (m_fetch == 0) begin
                        m_valid = 1; m_hold = m_pend; m_fetch = -1;
                    end
                end else if (!pre_valid && lvl != 0) begin
                    m_fetch = 1 + LAT;
                    m_pend  = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                end
                if (rel) m_valid = 0;
                exp_rd_en = (m_fetch == 1 + LAT);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("irq", {31'd0, irq}, {31'd0, m_valid});
            check("q_rd_en", {31'd0, q_rd_en}, {31'd0, exp_rd_en});
            check("bus_rdata", bus_if.bus_rdata, m_rdata);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        bus_if.bus_addr = a; bus_if.bus_rd = 1'b1;
        @(negedge clk);
        bus_if.bus_rd = 1'b0;
        d = bus_if.bus_rdata;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] w);
        @(negedge clk);
        bus_if.bus_addr = a; bus_if.bus_wdata = w; bus_if.bus_wr = 1'b1;
        @(negedge clk);
        bus_if.bus_wr = 1'b0;
    endtask

    task automatic wait_irq(output int pulses, output int gap);
        int last;
        pulses = 0; last = -100; gap = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (q_rd_en) begin pulses++; last = i; end
            if (irq) begin gap = i - last; return; end
        end
        check("wait_irq_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [31:0]  d;
        logic [127:0] e;
        int pulses, gap, lat;
        bit seen;

        rst_n = 1'b0;
        bus_if.bus_addr = '0; bus_if.bus_rd = 0; bus_if.bus_wr = 0; bus_if.bus_wdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_q_rd_en", {31'd0, q_rd_en}, 32'd0);
        bus_read(3'd0, d); check("rst_stat", d, 32'h0000_0000);
        bus_read(3'd1, d); check("rst_ctrl", d, 32'h0000_0004);

        push({16'd0, 48'h0000_1234_5678, 32'h0ABC_DEF0, 32'h1055_0007});
        wait_irq(pulses, gap);
        check("one_rd_en_pulses", pulses, 1);
        check("one_rd_en_to_valid", gap, 2);
        bus_read(3'd2, d); check("data0", d, 32'h1055_0007);
        bus_read(3'd3, d); check("data1", d, 32'h0ABC_DEF0);
        bus_read(3'd4, d); check("data2", d, 32'h1234_5678);
        bus_read(3'd5, d); check("data3", d, 32'h0000_0000);
        check("irq_after_pop", {31'd0, irq}, 32'd0);
        bus_read(3'd0, d); check("stat_after_pop", d, 32'h0001_0000);

        bus_write(3'd1, 32'h0);
        push({16'd0, 48'hAAAA_0000_0001, 32'h0000_0011, 32'h0000_0001});
        push({16'd0, 48'hBBBB_0000_0002, 32'h0000_0022, 32'h0000_0002});
        push({16'd0, 48'hCCCC_0000_0003, 32'h0000_0033, 32'h0000_0003});
        wait_irq(pulses, gap);
        check("a_pulses", pulses, 1);
        bus_read(3'd5, d); check("a_data3_1", d, 32'h0000_AAAA);
        bus_read(3'd5, d); check("a_data3_2", d, 32'h0000_AAAA);
        check("a_irq_held", {31'd0, irq}, 32'd1);
        bus_read(3'd0, d); check("a_stat_cnt", {16'd0, d[31:16]}, 32'd1);
        bus_write(3'd1, 32'h1);
        lat = 0; pulses = 0;
        while (!irq && lat < 12) begin
            @(negedge clk); lat++;
            if (q_rd_en) pulses++;
        end
        check("b_load_latency", lat, 3);
        check("b_pulses", pulses, 1);
        bus_read(3'd5, d); check("b_data3", d, 32'h0000_BBBB);
        bus_write(3'd1, 32'h3);
        bus_read(3'd0, d); check("clr_rel_cnt", {16'd0, d[31:16]}, 32'd0);
        wait_irq(pulses, gap);
        bus_read(3'd5, d); check("c_data3", d, 32'h0000_CCCC);
        bus_write(3'd1, 32'h1);
        bus_read(3'd0, d); check("c_stat_cnt", {16'd0, d[31:16]}, 32'd1);
        bus_write(3'd1, 32'h4);
        repeat (4) @(negedge clk);

        // Start the counter just short of wrap.
        force dut.cons_cnt_q = 16'hFFFE;
        #1;
        release dut.cons_cnt_q;
        m_cnt = 16'hFFFE;
        push({16'd0, 48'h0000_0000_00F1, 32'h0, 32'h0});
        push({16'd0, 48'h0000_0000_00F2, 32'h0, 32'h0});
        wait_irq(pulses, gap);
        bus_read(3'd5, d);
        bus_read(3'd0, d); check("cnt_ffff", {16'd0, d[31:16]}, 32'h0000_FFFF);
        wait_irq(pulses, gap);
        bus_read(3'd5, d);
        bus_read(3'd0, d); check("cnt_wrap", {16'd0, d[31:16]}, 32'h0000_0000);

        push({16'd0, 48'hDDDD_0000_0004, 32'h0D0D_0D0D, 32'h4});
        push({16'd0, 48'hEEEE_0000_0005, 32'h0E0E_0E0E, 32'h5});
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (q_rd_en) seen = 1;
        end
        check("d_rd_en_seen", {31'd0, seen}, 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_q_rd_en", {31'd0, q_rd_en}, 32'd0);
        check("mid_rst_irq", {31'd0, irq}, 32'd0);
        check("mid_rst_rdata", bus_if.bus_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("post_rst_irq", {31'd0, irq}, 32'd0);
        wait_irq(pulses, gap);
        check("e_pulses", pulses, 1);
        bus_read(3'd3, d); check("e_data1", d, 32'h0E0E_0E0E);
        bus_read(3'd5, d); check("e_data3", d, 32'h0000_EEEE);

        for (int i = 0; i < 3000; i++) begin
            int r;
            @(negedge clk);
            bus_if.bus_rd = 0; bus_if.bus_wr = 0;
            if ($urandom_range(0, 3) == 0 && sq.size() < 14) begin
                e = {$urandom, $urandom, $urandom, $urandom};
                e[127:112] = '0;
                push(e);
            end
            r = int'($urandom_range(0, 15));
            if (r < 5) begin
                bus_if.bus_rd = 1;
                bus_if.bus_addr = (r < 2) ? 3'd5 : 3'($urandom_range(0, 7));
            end else if (r == 5) begin
                bus_if.bus_wr = 1; bus_if.bus_addr = 3'd1;
                bus_if.bus_wdata = {$urandom} & 32'hFFFF_FFF5 | 32'h4;
                if ($urandom_range(0, 7) == 0) bus_if.bus_wdata[1] = 1'b1;
            end else if (r == 6) begin
                bus_if.bus_wr = 1; bus_if.bus_addr = 3'($urandom_range(0, 7));
                bus_if.bus_wdata = $urandom;
            end else if (r == 7) begin
                bus_if.bus_rd = 1; bus_if.bus_wr = 1;
                bus_if.bus_addr = 3'($urandom_range(0, 7));
                bus_if.bus_wdata = $urandom;
            end
        end
        @(negedge clk);
        bus_if.bus_rd = 0; bus_if.bus_wr = 0;
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
